// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Modulo-n increment without a divider: wraps n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr >= n - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first asserted request at or above ptr, wrapping mod NREQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic          w_found;
  logic [PW-1:0] w_pick;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int   j;
      logic hit;
      j       = int'(ptr) + k;
      j       = (j >= NREQ) ? (j - NREQ) : j;
      hit     = !w_found && req[j[PW-1:0]];
      w_pick  = hit ? PW'(j) : w_pick;
      w_found = w_found | hit;
    end
  end

  assign onehot = w_found ? (NREQ'(1) << w_pick) : '0;
  assign idx    = w_pick;
  assign any    = w_found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ valid/ready/last streams.
// Bursts are capped at MAX_BURST beats; wfull gates winc/ready combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int Dsize     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*Dsize-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [Dsize-1:0]      fifo_w_data,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_gidx;
  logic [PW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_beat_cnt;

  logic [NREQ-1:0]  w_pick_onehot;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_busy;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_xfer;
  logic             w_release;
  logic [BW-1:0]    w_beat_next;
  logic [Dsize-1:0] w_beats [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_beats[i] = req_data[i*Dsize +: Dsize];
  end

  fifo_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_busy      = (r_state == ARB_BURST);
  assign w_g_valid   = req_valid[r_gidx];
  assign w_g_last    = req_last[r_gidx];
  assign w_xfer      = w_busy & w_g_valid & ~fifo_wfull;
  assign w_beat_next = r_beat_cnt + BW'(1);

  // A stalled beat (valid but full) never releases; a dropped valid always does.
  assign w_release = w_busy &
                     ((w_xfer & (w_g_last | (w_beat_next == BW'(MAX_BURST)))) | ~w_g_valid);

  assign busy        = w_busy;
  assign grant       = r_grant;
  assign fifo_winc   = w_xfer;
  assign fifo_w_data = w_busy ? w_beats[r_gidx] : '0;
  assign req_ready   = (w_busy & ~fifo_wfull) ? r_grant : '0;

  // Arbitration state, grant ownership, burst beat count and round-robin pointer.
  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_state    <= ARB_BURST;
            r_grant    <= w_pick_onehot;
            r_gidx     <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        ARB_BURST: begin
          if (w_xfer) begin
            r_beat_cnt <= w_beat_next;
          end
          if (w_release) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= PW'(rr_next(32'(r_gidx), NREQ));
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DS   = 8;
  localparam int MB   = 4;

  logic                 wclk = 1'b0;
  logic                 w_rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DS-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [DS-1:0]        fifo_w_data;
  logic                 fifo_winc;
  logic                 fifo_wfull = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int m_owner;
  int m_ptr;
  int m_beats;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_grant;
    logic        e_winc;
    logic [7:0]  e_wdata;
  } vec_t;

  vec_t tbl [14];

  fifo_wr_arbiter #(.NREQ(NREQ), .Dsize(DS), .MAX_BURST(MB)) dut (
    .wclk        (wclk),
    .w_rst       (w_rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .fifo_w_data (fifo_w_data),
    .fifo_winc   (fifo_winc),
    .fifo_wfull  (fifo_wfull)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] beat_of(input logic [3:0] g);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) r = req_data[i*DS +: DS];
    end
    return r;
  endfunction

  // Compare every output given the expected owner vector and winc.
  task automatic check_all(input string tag, input logic [3:0] g, input logic w);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    chk({tag, ".winc"}, 32'(fifo_winc), 32'(w));
    chk({tag, ".wdata"}, 32'(fifo_w_data), 32'(beat_of(g)));
    chk({tag, ".ready"}, 32'(req_ready), 32'((|g && !fifo_wfull) ? g : 4'b0000));
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic f);
    @(negedge wclk);
    req_valid  = v;
    req_data   = d;
    req_last   = l;
    fifo_wfull = f;
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  // Expected outputs for the current cycle, derived from the model's owner.
  task automatic model_check(input string tag);
    logic [3:0] g;
    logic       w;
    g = 4'b0000;
    w = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      w = req_valid[m_owner] && !fifo_wfull;
    end
    check_all(tag, g, w);
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_advance();
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && req_valid[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_beats = 0;
        end
      end
    end else begin
      bit moved;
      moved = req_valid[m_owner] && !fifo_wfull;
      if (moved) m_beats++;
      if (!req_valid[m_owner] || (moved && (req_last[m_owner] || m_beats == MB))) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge wclk);
    w_rst      = 1'b1;
    req_valid  = 4'b1111;
    req_data   = 32'hDEADBEEF;
    fifo_wfull = 1'b0;
    #1;
    check_all("reset", 4'b0000, 1'b0);
    @(negedge wclk);
    req_valid = 4'b0000;
    w_rst     = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] eg;
    logic [3:0] lst;
    int         sent [NREQ];

    tbl[0]  = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0100, 1'b1, 8'hA1};
    tbl[2]  = '{4'b0100, 4'b0000, 32'h00A2_0000, 1'b0, 4'b0100, 1'b1, 8'hA2};
    tbl[3]  = '{4'b0100, 4'b0100, 32'h00A3_0000, 1'b0, 4'b0100, 1'b1, 8'hA3};
    tbl[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[5]  = '{4'b1111, 4'b0000, 32'hB300_00B0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[6]  = '{4'b1001, 4'b1000, 32'hB300_00B0, 1'b0, 4'b1000, 1'b1, 8'hB3};
    tbl[7]  = '{4'b0001, 4'b0001, 32'hB300_00B0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[8]  = '{4'b0001, 4'b0001, 32'hB300_00B0, 1'b0, 4'b0001, 1'b1, 8'hB0};
    tbl[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[10] = '{4'b0010, 4'b0010, 32'h0000_C100, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[11] = '{4'b0010, 4'b0010, 32'h0000_C100, 1'b1, 4'b0010, 1'b0, 8'hC1};
    tbl[12] = '{4'b0010, 4'b0010, 32'h0000_C100, 1'b0, 4'b0010, 1'b1, 8'hC1};
    tbl[13] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00};

    repeat (2) @(negedge wclk);
    do_reset();

    // Directed table: single requester burst, pointer wrap to 3 then 0, last held under full.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].full);
      chk($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(|tbl[i].e_grant));
      chk($sformatf("tbl%0d.winc", i), 32'(fifo_winc), 32'(tbl[i].e_winc));
      chk($sformatf("tbl%0d.wdata", i), 32'(fifo_w_data), 32'(tbl[i].e_wdata));
      chk($sformatf("tbl%0d.ready", i), 32'(req_ready),
          32'((|tbl[i].e_grant && !tbl[i].full) ? tbl[i].e_grant : 4'b0000));
    end

    // Fairness: all requesters valid with 2-beat packets -> 0,1,2,3,0 with bubbles.
    do_reset();
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NREQ; i++) lst[i] = (sent[i] % 2) == 1;
      drive(4'b1111, $urandom, lst, 1'b0);
      eg = 4'b0000;
      if (c % 3 != 0) eg[(c / 3) % NREQ] = 1'b1;
      check_all($sformatf("fair%0d", c), eg, |eg);
      if (c % 3 != 0) sent[(c / 3) % NREQ]++;
    end

    // MAX_BURST cap: req1 streams without last, req3 waits and sends one last beat.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      logic [3:0] exp_g [9];
      exp_g = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
      drive(4'b1010, $urandom, 4'b1000, 1'b0);
      check_all($sformatf("cap%0d", c), exp_g[c], |exp_g[c]);
    end

    // Full stall for 5 cycles mid-burst: count and grant hold, release after 4 real beats.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      logic f;
      f  = (c >= 2 && c <= 6);
      eg = (c >= 1 && c <= 9) ? 4'b0001 : 4'b0000;
      drive(4'b0001, $urandom, 4'b0000, f);
      check_all($sformatf("stall%0d", c), eg, |eg && !f);
    end

    // Valid drop with pointer wrap from 3 to 0.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      logic [3:0] vv [7];
      logic [3:0] ll [7];
      logic [3:0] gg [7];
      logic       ww [7];
      vv = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0011, 4'b0011};
      ll = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      gg = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
      ww = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      drive(vv[c], $urandom, ll[c], 1'b0);
      check_all($sformatf("drop%0d", c), gg[c], ww[c]);
    end

    // Asynchronous reset between edges during a transfer.
    do_reset();
    drive(4'b0010, 32'h0000_5500, 4'b0000, 1'b0);
    drive(4'b0010, 32'h0000_5600, 4'b0000, 1'b0);
    check_all("arst.pre", 4'b0010, 1'b1);
    #1 w_rst = 1'b1;
    #1 check_all("arst.now", 4'b0000, 1'b0);
    @(negedge wclk);
    w_rst     = 1'b0;
    req_valid = 4'b0011;
    drive(4'b0011, 32'h0000_7170, 4'b0011, 1'b0);
    check_all("arst.after", 4'b0001, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] v;
      logic [3:0] l;
      for (int i = 0; i < NREQ; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        l[i] = ($urandom_range(0, 9) < 3);
      end
      drive(v, $urandom, l, $urandom_range(0, 3) == 0);
      model_check($sformatf("rnd%0d", c));
      model_advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
